// File: rtl/astropix_spi_pkg.sv
// Shared types and constants for the AstroPix SPI responder.
//   state_e           : responder FSM state (IDLE, SHIFT)
//   HIT_WIDTH         : width of a queued hit word
//   CMD_WIDTH         : width of a captured MOSI command byte
//   DEFAULT_IDLE_BYTE : byte sent on each MISO lane when no hit is queued
package astropix_spi_pkg;

    localparam int unsigned HIT_WIDTH = 16;
    localparam int unsigned CMD_WIDTH = 8;
    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hBC;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/astropix_spi_responder_hit_fifo.sv
// hit_fifo: single-clock first-word-fall-through FIFO for hit words.
// Ports:
//   clock, reset     : system clock, asynchronous active-high reset
//   push, push_data  : write request and data (ignored when full)
//   pop              : read request (ignored when empty)
//   pop_data         : head entry, valid whenever empty is low
//   level            : current occupancy, 0..FIFO_DEPTH
//   full, empty      : occupancy flags; empty is a flop updated with level
module hit_fifo
    import astropix_spi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [HIT_WIDTH-1:0]          push_data,
    input  logic                          pop,
    output logic [HIT_WIDTH-1:0]          pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [HIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 empty_q;
    logic                 do_push, do_pop;

    assign full    = (count_q == DEPTH_L);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign level    = count_q;
    assign empty    = empty_q;

endmodule

// File: rtl/astropix_spi_responder.sv
// astropix_spi_responder: FPGA emulation of the AstroPix dual-MISO SPI readout.
// Oversamples the master's SCK/CSn/MOSI on the system clock, shifts queued hit words out
// on two lanes (high byte on miso0, low byte on miso1), captures MOSI bytes as commands
// and holds interrupt_n low while hits are pending.
// Ports:
//   clock, reset         : system clock, asynchronous active-high reset
//   spi_clk/csn/mosi     : master pins (CPOL=0), asynchronous to clock
//   spi_miso0/1          : data lanes, MSB first, 0 while deselected
//   hit_data/valid/ready : hit word push handshake into the FIFO
//   cmd_data, cmd_valid  : last complete MOSI byte and its one-cycle strobe
//   interrupt_n          : low while the FIFO is non-empty
//   fifo_level           : FIFO occupancy
module astropix_spi_responder
    import astropix_spi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  IDLE_BYTE   = DEFAULT_IDLE_BYTE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          spi_clk,
    input  logic                          spi_csn,
    input  logic                          spi_mosi,
    output logic                          spi_miso0,
    output logic                          spi_miso1,
    input  logic [HIT_WIDTH-1:0]          hit_data,
    input  logic                          hit_valid,
    output logic                          hit_ready,
    output logic [CMD_WIDTH-1:0]          cmd_data,
    output logic                          cmd_valid,
    output logic                          interrupt_n,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // Pin bundle order {sck, csn, mosi}; csn resets high so reset release is not a select.
    localparam logic [2:0] PIN_RESET = 3'b010;

    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] pins_q;
    logic [2:0] sync_out;
    logic       sck_rise_q, sck_fall_q, csn_fall_q, csn_rise_q;
    logic       mosi_s;

    state_e               state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           rx_q, rx_d;
    logic [7:0]           tx_hi_q, tx_hi_d;
    logic [7:0]           tx_lo_q, tx_lo_d;
    logic [CMD_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic                 cmd_valid_q, cmd_valid_d;

    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [HIT_WIDTH-1:0] fifo_rd_data;
    logic [HIT_WIDTH-1:0] next_word;

    // Synchronizers, then a registered edge detect. pins_q holds the sample that produced
    // the current event, so mosi_s lines up with sck_rise_q.
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_RESET;
            pins_q     <= PIN_RESET;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            csn_fall_q <= 1'b0;
            csn_rise_q <= 1'b0;
        end else begin
            sync_q[0] <= {spi_clk, spi_csn, spi_mosi};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            pins_q     <= sync_out;
            // SCK edges are only meaningful while selected.
            sck_rise_q <= sync_out[2] & ~pins_q[2] & ~sync_out[1];
            sck_fall_q <= ~sync_out[2] & pins_q[2] & ~sync_out[1];
            csn_fall_q <= ~sync_out[1] & pins_q[1];
            csn_rise_q <= sync_out[1] & ~pins_q[1];
        end
    end

    assign mosi_s = pins_q[0];

    hit_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (hit_valid & hit_ready),
        .push_data (hit_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Word presented at a load point: FIFO head if any, otherwise the idle pattern.
    assign next_word = fifo_empty ? {IDLE_BYTE, IDLE_BYTE} : fifo_rd_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_hi_q     <= '0;
            tx_lo_q     <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_hi_q     <= tx_hi_d;
            tx_lo_q     <= tx_lo_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_hi_d     = tx_hi_q;
        tx_lo_d     = tx_lo_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (csn_fall_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_hi_d   = next_word[15:8];
                    tx_lo_d   = next_word[7:0];
                    fifo_pop  = ~fifo_empty;
                end
            end
            SHIFT: begin
                if (csn_rise_q) begin
                    // Partial byte dropped; an already popped word stays consumed.
                    state_d = IDLE;
                end else begin
                    if (sck_rise_q) begin
                        rx_d      = {rx_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_data_d  = {rx_q[6:0], mosi_s};
                            cmd_valid_d = 1'b1;
                        end
                    end
                    if (sck_fall_q) begin
                        if (bit_cnt_q != 3'd0) begin
                            tx_hi_d = {tx_hi_q[6:0], 1'b0};
                            tx_lo_d = {tx_lo_q[6:0], 1'b0};
                        end else begin
                            // Byte boundary: the fall after the 8th rise starts the next word.
                            tx_hi_d  = next_word[15:8];
                            tx_lo_d  = next_word[7:0];
                            fifo_pop = ~fifo_empty;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_miso0   = (state_q == SHIFT) & tx_hi_q[7];
    assign spi_miso1   = (state_q == SHIFT) & tx_lo_q[7];
    assign hit_ready   = ~fifo_full;
    assign interrupt_n = fifo_empty;
    assign cmd_data    = cmd_data_q;
    assign cmd_valid   = cmd_valid_q;

endmodule

// File: tb/tb_astropix_spi_responder.sv
module tb_astropix_spi_responder;

    localparam int DEPTH = 16;
    localparam int HALF  = 6;   // system clocks per SCK half period

    logic        clock, reset;
    logic        spi_clk, spi_csn, spi_mosi;
    logic        spi_miso0, spi_miso1;
    logic [15:0] hit_data;
    logic        hit_valid, hit_ready;
    logic [7:0]  cmd_data;
    logic        cmd_valid, interrupt_n;
    logic [4:0]  fifo_level;

    astropix_spi_responder #(
        .FIFO_DEPTH  (16),
        .IDLE_BYTE   (8'hBC),
        .SYNC_STAGES (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso0   (spi_miso0),
        .spi_miso1   (spi_miso1),
        .hit_data    (hit_data),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .interrupt_n (interrupt_n),
        .fifo_level  (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] hq[$];          // model of FIFO contents
    logic [15:0] exp_words[$];   // words the DUT is expected to shift out
    logic [7:0]  cmd_exp[$];     // command bytes the DUT is expected to strobe
    logic [7:0]  mon_exp;
    logic        cv_prev = 1'b0;

    // Command monitor: every strobe is matched against the scoreboard.
    always @(negedge clock) begin
        if (!reset && cmd_valid) begin
            n_tests++;
            if (cmd_exp.size() == 0) begin
                n_fail++;
                $display("FAIL cmd_unexpected: got cmd_valid=1 data=%h required no strobe", cmd_data);
            end else begin
                mon_exp = cmd_exp.pop_front();
                if (cmd_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL cmd_data: got %h required %h", cmd_data, mon_exp);
                end
            end
            n_tests++;
            if (cv_prev !== 1'b0) begin
                n_fail++;
                $display("FAIL cmd_valid_width: got 2+ cycle strobe required 1 cycle");
            end
        end
        cv_prev = cmd_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] model_pop();
        logic [15:0] w;
        if (hq.size() != 0) w = hq.pop_front();
        else                w = 16'hBCBC;
        return w;
    endfunction

    task automatic do_reset();
        reset = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        hit_valid = 1'b0; hit_data = '0;
        tick(3);
        reset = 1'b0;
        hq.delete(); exp_words.delete(); cmd_exp.delete();
        tick(3);
    endtask

    task automatic push_hit(input logic [15:0] d);
        logic exp_acc;
        exp_acc   = (hq.size() < DEPTH);
        hit_data  = d;
        hit_valid = 1'b1;
        n_tests++;
        if (hit_ready !== exp_acc) begin
            n_fail++;
            $display("FAIL hit_ready: got %b required %b (model level %0d)", hit_ready, exp_acc, hq.size());
        end
        @(posedge clock); #1;
        hit_valid = 1'b0;
        if (exp_acc) hq.push_back(d);
        n_tests++;
        if (fifo_level !== 5'(hq.size()) || interrupt_n !== (hq.size() == 0)) begin
            n_fail++;
            $display("FAIL push_level: got level=%0d int_n=%b required level=%0d int_n=%b",
                     fifo_level, interrupt_n, hq.size(), hq.size() == 0);
        end
    endtask

    // One CSn-low transaction of nsck SCK cycles; MOSI sends mosi_word MSB first.
    task automatic xfer(input int nsck, input logic [15:0] mosi_word);
        logic [7:0]  b0, b1;
        logic [15:0] e;
        b0 = '0; b1 = '0;
        exp_words.delete();
        spi_csn = 1'b0;
        exp_words.push_back(model_pop());
        tick(10);
        for (int i = 0; i < nsck; i++) begin
            spi_mosi = mosi_word[15 - (i % 16)];
            tick(HALF);
            b0 = {b0[6:0], spi_miso0};
            b1 = {b1[6:0], spi_miso1};
            if (i % 8 == 7) begin
                e = exp_words.pop_front();
                n_tests++;
                if ({b0, b1} !== e) begin
                    n_fail++;
                    $display("FAIL miso_word: got miso0=%h miso1=%h required %h/%h",
                             b0, b1, e[15:8], e[7:0]);
                end
                exp_words.push_back(model_pop());
                cmd_exp.push_back((i % 16 == 7) ? mosi_word[15:8] : mosi_word[7:0]);
            end
            spi_clk = 1'b1;
            tick(HALF);
            spi_clk = 1'b0;
        end
        tick(HALF);
        spi_csn = 1'b1;
        tick(6);
        n_tests++;
        if (spi_miso0 !== 1'b0 || spi_miso1 !== 1'b0) begin
            n_fail++;
            $display("FAIL miso_deselect: got %b%b required 00", spi_miso0, spi_miso1);
        end
        tick(8);
    endtask

    task automatic check_idle_flags(input string name);
        n_tests++;
        if (fifo_level !== 5'(hq.size()) || interrupt_n !== (hq.size() == 0) ||
            hit_ready !== (hq.size() < DEPTH)) begin
            n_fail++;
            $display("FAIL %s: got level=%0d int_n=%b ready=%b required level=%0d int_n=%b ready=%b",
                     name, fifo_level, interrupt_n, hit_ready, hq.size(), hq.size() == 0,
                     hq.size() < DEPTH);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_tests++;
        if (spi_miso0 !== 1'b0 || spi_miso1 !== 1'b0 || hit_ready !== 1'b1 ||
            cmd_data !== 8'h00 || cmd_valid !== 1'b0 || interrupt_n !== 1'b1 ||
            fifo_level !== 5'd0) begin
            n_fail++;
            $display("FAIL %s: got miso=%b%b ready=%b cmd=%h cv=%b int_n=%b level=%0d required 00 1 00 0 1 0",
                     name, spi_miso0, spi_miso1, hit_ready, cmd_data, cmd_valid, interrupt_n,
                     fifo_level);
        end
    endtask

    task automatic check_cmd_drained(input string name);
        tick(10);
        n_tests++;
        if (cmd_exp.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d missing cmd strobes required 0", name, cmd_exp.size());
        end
        cmd_exp.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        hit_valid = 1'b0; hit_data = '0;
        tick(3);
        check_reset_values("reset_values");
        reset = 1'b0;
        tick(3);
        check_reset_values("after_reset_release");
    endtask

    task automatic test_idle_words();
        do_reset();
        xfer(16, 16'h0000);
        check_idle_flags("idle_flags");
        check_cmd_drained("idle_cmds");
    endtask

    task automatic test_hit_words();
        do_reset();
        push_hit(16'h1234);
        push_hit(16'hABCD);
        xfer(16, 16'hFFFF);
        check_idle_flags("hit_drained");
        check_cmd_drained("hit_cmds");
    endtask

    task automatic test_cmd_capture();
        do_reset();
        xfer(16, 16'hA53C);
        check_cmd_drained("cmd_capture");
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_hit(16'h1000 + 16'(i));
        push_hit(16'hDEAD);               // refused while full
        check_idle_flags("full_flags");
        xfer(4, 16'h0000);                // pops exactly one word
        check_idle_flags("after_one_read");
        xfer(8, 16'h5A00);                // next word in order, then boundary pop
        check_idle_flags("after_second_read");
        check_cmd_drained("full_cmds");
    endtask

    task automatic test_abort();
        do_reset();
        push_hit(16'h1111);
        push_hit(16'h2222);
        push_hit(16'h3333);
        xfer(5, 16'hFFFF);                // consumes 0x1111, no command
        check_idle_flags("abort_flags");
        check_cmd_drained("abort_no_cmd");
        xfer(8, 16'h96FF);
        check_idle_flags("abort_resume_flags");
        check_cmd_drained("abort_resume_cmd");
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_hit(16'h0F0F);
        push_hit(16'hF0F0);
        push_hit(16'h5555);
        spi_csn = 1'b0;
        tick(10);
        for (int i = 0; i < 3; i++) begin
            spi_mosi = 1'b1;
            tick(HALF); spi_clk = 1'b1;
            tick(HALF); spi_clk = 1'b0;
        end
        tick(2);
        reset = 1'b1;
        #1;
        check_reset_values("reset_mid_immediate");
        spi_csn = 1'b1; spi_clk = 1'b0;
        tick(3);
        reset = 1'b0;
        hq.delete(); cmd_exp.delete();
        tick(10);
        check_reset_values("reset_mid_after");
    endtask

    initial begin
        test_reset();
        test_idle_words();
        test_hit_words();
        test_cmd_capture();
        test_fifo_full();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
